// File: rtl/sync_fifo_pkg.sv
// Shared constants for the single-clock FIFO: default geometry and the derived depth.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write port, registered synchronous read port.
module sync_fifo_ram #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    localparam int RAM_DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [0:RAM_DEPTH-1];
    logic [DW-1:0] rd_data_q;

    // Storage is deliberately left unreset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO control: pointers, occupancy count, flags and accept gating around the RAM.
module sync_fifo_core
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_wr_en,
    input  logic                       fifo_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_wr_data,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_data_cnt,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data
);

    localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};

    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                       wr_acc, rd_acc;

    // Flags come straight from the count register, so accepts see pre-edge state.
    assign fifo_full     = (cnt_q == FULL_CNT);
    assign fifo_empty    = (cnt_q == '0);
    assign fifo_data_cnt = cnt_q;

    assign wr_acc = fifo_wr_en & ~fifo_full;
    assign rd_acc = fifo_rd_en & ~fifo_empty;

    assign wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    sync_fifo_ram #(
        .DW (FIFO_DATA_WIDTH),
        .AW (FIFO_ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (fifo_wr_data),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (fifo_rd_data)
    );

endmodule

// File: tb/tb_sync_fifo_core.sv
// Scoreboard bench for sync_fifo_core against a queue-based reference model.
module tb_sync_fifo_core;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [DW-1:0] wd = '0;
    logic          fifo_full, fifo_empty;
    logic [AW:0]   fifo_data_cnt;
    logic [DW-1:0] fifo_rd_data;

    always #5 clk = ~clk;

    sync_fifo_core #(.FIFO_DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_wr_en    (we),
        .fifo_rd_en    (re),
        .fifo_wr_data  (wd),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_data_cnt (fifo_data_cnt),
        .fifo_rd_data  (fifo_rd_data)
    );

    typedef struct {
        int          cnt;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mq[$];
    logic [31:0] last_rd = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue; acceptance decided from occupancy before the edge.
    task automatic cycle(input logic w, input logic r, input logic [31:0] d);
        exp_t e;
        bit   wa, ra;
        @(negedge clk);
        we = w; re = r; wd = d;
        wa = w && (mq.size() < DEPTH);
        ra = r && (mq.size() > 0);
        if (ra) last_rd = mq.pop_front();
        if (wa) mq.push_back(d);
        e.cnt  = mq.size();
        e.data = last_rd;
        @(posedge clk);
        sb.push_back(e);
    endtask

    task automatic do_reset(input int hold_ns);
        @(negedge clk);
        we = 1'b0; re = 1'b0; wd = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_empty", 64'(fifo_empty), 64'(1));
        chk("rst_full",  64'(fifo_full),  64'(0));
        chk("rst_cnt",   64'(fifo_data_cnt), 64'(0));
        chk("rst_rdata", 64'(fifo_rd_data),  64'(0));
        mq.delete();
        last_rd = '0;
        #(hold_ns);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every pushed expectation is compared just after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cnt",   64'(fifo_data_cnt), 64'(e.cnt));
                chk("rdata", 64'(fifo_rd_data),  64'(e.data));
                chk("full",  64'(fifo_full),     64'(e.cnt == DEPTH));
                chk("empty", 64'(fifo_empty),    64'(e.cnt == 0));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   writes;
        logic w, r;

        do_reset(300);

        // Streaming: fill three, then overlapped read/write.
        cycle(1'b1, 1'b0, 32'd2);
        cycle(1'b1, 1'b0, 32'd4);
        cycle(1'b1, 1'b0, 32'd6);
        cycle(1'b1, 1'b1, 32'd8);
        cycle(1'b1, 1'b1, 32'd10);
        cycle(1'b1, 1'b1, 32'd12);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 32'd12);

        // Fill to full, overflow attempts, then drain past empty.
        do_reset(20);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 32'(i));
        cycle(1'b1, 1'b0, 32'hDEAD);
        cycle(1'b1, 1'b1, 32'hBEEF);
        cycle(1'b1, 1'b0, 32'd256);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 32'(i));
        cycle(1'b0, 1'b1, 32'h0);

        // Simultaneous on empty: only the write lands.
        cycle(1'b1, 1'b1, 32'h1234_5678);

        // Wrap-around with small occupancy.
        writes = 0;
        for (int k = 0; k < 5000 && writes < 600; k++) begin
            w = (mq.size() < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            r = (mq.size() > 1)  ? 1'($urandom_range(0, 1)) : 1'b0;
            if (w) writes++;
            cycle(w, r, $urandom);
        end

        // Unconstrained random traffic, then a reset mid-stream.
        for (int k = 0; k < 300; k++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        do_reset(10);
        for (int k = 0; k < 30; k++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

        @(negedge clk);
        we = 1'b0; re = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
